// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared types and constants for the data-memory / MMIO bus arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_bus_arbiter_pkg;

  // Dm_ctrl is the CPU's size/sign code; the arbiter only carries it through.
  localparam int DM_CTRL_W = 3;
  typedef logic [DM_CTRL_W-1:0] dm_ctrl_t;

  // Master identifiers, also used as the grant_id encoding.
  localparam logic MST_CPU = 1'b0;
  localparam logic MST_AUX = 1'b1;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // One captured master request, held stable for the whole slave access.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    dm_ctrl_t    dm_ctrl;
  } mem_req_t;

endpackage

// File: rtl/dmem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick between the CPU port and the auxiliary port.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arb2
  import dmem_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // A lone requester wins outright; on a tie the master that did not win last time goes.
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = MST_CPU;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else if (req1) begin
      grant_id = MST_AUX;
    end
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter and wait-state sequencer for the shared data memory / MMIO port.
// Latency: request seen in IDLE -> WAIT_CYCLES+1 ACCESS cycles -> one RESP cycle with ready.
// Backpressure: requests are only sampled in IDLE; a master waits (req held) until its ready pulse.
module dmem_bus_arbiter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,  // extra slave cycles, 0..15
  parameter int CNT_W       = 4   // must satisfy 2**CNT_W > WAIT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [31:0]          m0_addr,
  input  logic [31:0]          m0_wdata,
  input  logic [DM_CTRL_W-1:0] m0_dm_ctrl,
  output logic                 m0_ready,
  output logic [31:0]          m0_rdata,

  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [31:0]          m1_addr,
  input  logic [31:0]          m1_wdata,
  input  logic [DM_CTRL_W-1:0] m1_dm_ctrl,
  output logic                 m1_ready,
  output logic [31:0]          m1_rdata,

  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [DM_CTRL_W-1:0] s_dm_ctrl,
  output logic                 s_we,
  input  logic [31:0]          s_rdata,

  output logic                 busy,
  output logic                 grant_id
);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_grant_q;
  logic             grant_id_q;
  mem_req_t         req_q;
  mem_req_t         win_req;
  logic [31:0]      m0_rdata_q;
  logic [31:0]      m1_rdata_q;

  logic             arb_vld;
  logic             arb_id;
  logic             grant_take;
  logic             access_last;

  rr_arb2 u_rr_arb2 (
    .req0        (m0_req),
    .req1        (m1_req),
    .last_grant  (last_grant_q),
    .grant_valid (arb_vld),
    .grant_id    (arb_id)
  );

  // A grant only happens from IDLE, so requests arriving mid-transfer are ignored.
  assign grant_take  = (state_q == IDLE) && arb_vld;
  // Final ACCESS cycle: write strobe fires and read data is captured here.
  assign access_last = (state_q == ACCESS) && (cnt_q == '0);

  // Select the winning master's request fields for capture.
  always_comb begin
    win_req.we      = m0_we;
    win_req.addr    = m0_addr;
    win_req.wdata   = m0_wdata;
    win_req.dm_ctrl = m0_dm_ctrl;
    if (arb_id == MST_AUX) begin
      win_req.we      = m1_we;
      win_req.addr    = m1_addr;
      win_req.wdata   = m1_wdata;
      win_req.dm_ctrl = m1_dm_ctrl;
    end
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; slave and ready outputs are zero outside their states.
  always_comb begin
    state_d   = state_q;
    s_addr    = '0;
    s_wdata   = '0;
    s_dm_ctrl = '0;
    s_we      = 1'b0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        s_addr    = req_q.addr;
        s_wdata   = req_q.wdata;
        s_dm_ctrl = req_q.dm_ctrl;
        s_we      = access_last & req_q.we;
        if (cnt_q == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // Writes return zero data, but the held read value survives for later.
        if (grant_id_q == MST_CPU) begin
          m0_ready = 1'b1;
          if (req_q.we) begin
            m0_rdata = '0;
          end
        end else begin
          m1_ready = 1'b1;
          if (req_q.we) begin
            m1_rdata = '0;
          end
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Wait-state counter: loaded on grant, counts down through ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (grant_take) begin
      cnt_q <= CNT_W'(WAIT_CYCLES);
    end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Capture the winner's request and record ownership; last_grant starts at AUX so CPU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q        <= '0;
      grant_id_q   <= MST_CPU;
      last_grant_q <= MST_AUX;
    end else if (grant_take) begin
      req_q        <= win_req;
      grant_id_q   <= arb_id;
      last_grant_q <= arb_id;
    end
  end

  // Per-master read data holding registers, updated only by that master's reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else if (access_last && !req_q.we) begin
      if (grant_id_q == MST_CPU) begin
        m0_rdata_q <= s_rdata;
      end else begin
        m1_rdata_q <= s_rdata;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Bench for dmem_bus_arbiter: WAIT_CYCLES=1 and WAIT_CYCLES=0 instances share one stimulus stream.
// Latency: each instance is compared every cycle against a transaction-level timing model.
// Backpressure: the modelled slave returns data only in the final access cycle.
module tb_dmem_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_dm_ctrl, m1_dm_ctrl;

  logic        m0_ready_o [2];
  logic        m1_ready_o [2];
  logic [31:0] m0_rdata_o [2];
  logic [31:0] m1_rdata_o [2];
  logic [31:0] s_addr_o   [2];
  logic [31:0] s_wdata_o  [2];
  logic [2:0]  s_dm_ctrl_o[2];
  logic        s_we_o     [2];
  logic [31:0] s_rdata_i  [2];
  logic        busy_o     [2];
  logic        grant_id_o [2];
  logic [135:0] obs       [2];

  int checks = 0;
  int failures = 0;

  // Model: instance 0 has WAIT_CYCLES=1, instance 1 has WAIT_CYCLES=0.
  int          W      [2] = '{1, 0};
  bit          m_act  [2];
  int          m_age  [2];   // cycles since the granting edge; ACCESS is age 0..W, RESP is W+1
  bit          m_own  [2];
  bit          m_last [2];
  logic        m_we   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [2:0]  m_ctrl [2];
  logic [31:0] m_hold [2][2];

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h0F0F_1234);
  endfunction

  // Slave returns valid data only in the final access cycle.
  assign s_rdata_i[0] = (m_act[0] && m_age[0] == 1) ? rd_fn(m_addr[0]) : 32'hBAD0_0BAD;
  assign s_rdata_i[1] = (m_act[1] && m_age[1] == 0) ? rd_fn(m_addr[1]) : 32'hBAD0_0BAD;

  dmem_bus_arbiter #(.WAIT_CYCLES(1), .CNT_W(4)) dut_w1 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_dm_ctrl(m0_dm_ctrl),
    .m0_ready(m0_ready_o[0]), .m0_rdata(m0_rdata_o[0]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_dm_ctrl(m1_dm_ctrl),
    .m1_ready(m1_ready_o[0]), .m1_rdata(m1_rdata_o[0]),
    .s_addr(s_addr_o[0]), .s_wdata(s_wdata_o[0]), .s_dm_ctrl(s_dm_ctrl_o[0]), .s_we(s_we_o[0]),
    .s_rdata(s_rdata_i[0]), .busy(busy_o[0]), .grant_id(grant_id_o[0])
  );

  dmem_bus_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) dut_w0 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_dm_ctrl(m0_dm_ctrl),
    .m0_ready(m0_ready_o[1]), .m0_rdata(m0_rdata_o[1]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_dm_ctrl(m1_dm_ctrl),
    .m1_ready(m1_ready_o[1]), .m1_rdata(m1_rdata_o[1]),
    .s_addr(s_addr_o[1]), .s_wdata(s_wdata_o[1]), .s_dm_ctrl(s_dm_ctrl_o[1]), .s_we(s_we_o[1]),
    .s_rdata(s_rdata_i[1]), .busy(busy_o[1]), .grant_id(grant_id_o[1])
  );

  // grant_id is only meaningful while busy, so it is masked by busy.
  for (genvar g = 0; g < 2; g++) begin : g_obs
    assign obs[g] = {busy_o[g], grant_id_o[g] & busy_o[g], s_we_o[g], s_addr_o[g], s_wdata_o[g],
                     s_dm_ctrl_o[g], m0_ready_o[g], m1_ready_o[g], m0_rdata_o[g], m1_rdata_o[g]};
  end

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_age[k] = 0; m_own[k] = 0; m_last[k] = 1;
      m_we[k] = 0; m_addr[k] = 0; m_wdata[k] = 0; m_ctrl[k] = 0;
      m_hold[k][0] = 0; m_hold[k][1] = 0;
    end
  endfunction

  // Advance the model across one rising edge using the inputs present at that edge.
  function automatic void model_edge();
    bit p;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_act[k] = 0; m_age[k] = 0; m_own[k] = 0; m_last[k] = 1;
        m_hold[k][0] = 0; m_hold[k][1] = 0;
      end else if (!m_act[k]) begin
        if (m0_req || m1_req) begin
          p = (m0_req && m1_req) ? !m_last[k] : !m0_req;
          m_we[k]    = p ? m1_we : m0_we;
          m_addr[k]  = p ? m1_addr : m0_addr;
          m_wdata[k] = p ? m1_wdata : m0_wdata;
          m_ctrl[k]  = p ? m1_dm_ctrl : m0_dm_ctrl;
          m_own[k] = p; m_last[k] = p; m_act[k] = 1; m_age[k] = 0;
        end
      end else begin
        if (m_age[k] == W[k] && !m_we[k]) m_hold[k][m_own[k]] = rd_fn(m_addr[k]);
        m_age[k]++;
        if (m_age[k] > W[k] + 1) m_act[k] = 0;
      end
    end
  endfunction

  function automatic logic [135:0] exp_vec(input int k);
    logic acc, resp, r0, r1;
    logic [31:0] d0, d1;
    acc  = m_act[k] && (m_age[k] <= W[k]);
    resp = m_act[k] && (m_age[k] == W[k] + 1);
    r0 = resp && (m_own[k] == 1'b0);
    r1 = resp && (m_own[k] == 1'b1);
    d0 = (r0 && m_we[k]) ? 32'h0 : m_hold[k][0];
    d1 = (r1 && m_we[k]) ? 32'h0 : m_hold[k][1];
    return {m_act[k], m_act[k] & m_own[k], acc && (m_age[k] == W[k]) && m_we[k],
            acc ? m_addr[k] : 32'h0, acc ? m_wdata[k] : 32'h0, acc ? m_ctrl[k] : 3'h0,
            r0, r1, d0, d1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1 model_edge();
    @(negedge clk);
  endtask

  task automatic set_m0(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; m0_dm_ctrl = c;
  endtask

  task automatic set_m1(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; m1_dm_ctrl = c;
  endtask

  task automatic idle_both();
    m0_req = 0; m1_req = 0;
    repeat (4) tick();
  endtask

  task automatic pulse_reset();
    reset = 0; model_reset();
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 136'h0) begin
        failures++; $display("FAIL reset_outputs inst=%0d got=%h want=0", k, obs[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        failures++; $display("FAIL reset_hold inst=%0d got=%h want=%h", k, obs[k], exp_vec(k));
      end
    end
    reset = 1;
  endtask

  task automatic test_cpu_read();
    idle_both();
    set_m0(1, 0, 32'h10, 32'h0, 3'b010);
    for (int c = 1; c <= 5; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          failures++; $display("FAIL cpu_read inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
      checks++;
      if ((c <= 2 && s_addr_o[0] !== 32'h10) || (c == 3 && (m0_ready_o[0] !== 1'b1 || m0_rdata_o[0] !== 32'hDEAD_BEEF))
          || (c == 4 && busy_o[0] !== 1'b0)) begin
        failures++; $display("FAIL cpu_read_timing cyc=%0d got addr=%h rdy=%b rdata=%h busy=%b", c,
                             s_addr_o[0], m0_ready_o[0], m0_rdata_o[0], busy_o[0]);
      end
      if (c == 3) m0_req = 0;
    end
  endtask

  task automatic test_cpu_write();
    idle_both();
    set_m0(1, 1, 32'h20, 32'h1234_5678, 3'b000);
    for (int c = 1; c <= 5; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          failures++; $display("FAIL cpu_write inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
      checks++;
      if (s_we_o[0] !== (c == 2) || (c == 2 && s_wdata_o[0] !== 32'h1234_5678)
          || m0_ready_o[0] !== (c == 3) || (c == 3 && m0_rdata_o[0] !== 32'h0)) begin
        failures++; $display("FAIL cpu_write_timing cyc=%0d got we=%b wdata=%h rdy=%b rdata=%h", c,
                             s_we_o[0], s_wdata_o[0], m0_ready_o[0], m0_rdata_o[0]);
      end
      if (c == 3) m0_req = 0;
    end
  endtask

  task automatic test_tie();
    idle_both();
    pulse_reset();
    set_m0(1, 0, 32'h44, 32'h0, 3'b010);
    set_m1(1, 1, 32'h88, 32'hA5A5_5A5A, 3'b001);
    for (int c = 1; c <= 12; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          failures++; $display("FAIL tie inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
      checks++;
      if ((c == 1 && grant_id_o[0] !== 1'b0) || (c == 5 && grant_id_o[0] !== 1'b1) || (c == 9 && grant_id_o[0] !== 1'b0)
          || m0_ready_o[0] !== (c == 3 || c == 11) || m1_ready_o[0] !== (c == 7)) begin
        failures++; $display("FAIL tie_order cyc=%0d got gid=%b r0=%b r1=%b", c, grant_id_o[0], m0_ready_o[0], m1_ready_o[0]);
      end
    end
    idle_both();
  endtask

  task automatic test_async_reset();
    idle_both();
    set_m0(1, 1, 32'h40, 32'h0000_CAFE, 3'b010);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        failures++; $display("FAIL arst_pre inst=%0d got=%h want=%h", k, obs[k], exp_vec(k));
      end
    end
    #2 reset = 0; model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 136'h0) begin
        failures++; $display("FAIL arst_immediate inst=%0d got=%h want=0", k, obs[k]);
      end
    end
    for (int c = 1; c <= 2; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== 136'h0) begin
          failures++; $display("FAIL arst_held inst=%0d cyc=%0d got=%h want=0", k, c, obs[k]);
        end
      end
    end
    reset = 1;
    set_m0(1, 0, 32'h50, 32'h0, 3'b010);
    set_m1(1, 0, 32'h60, 32'h0, 3'b010);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k) || grant_id_o[k] !== 1'b0 || busy_o[k] !== 1'b1) begin
        failures++; $display("FAIL arst_first_tie inst=%0d got=%h gid=%b want=%h gid=0", k, obs[k], grant_id_o[k], exp_vec(k));
      end
    end
    idle_both();
  endtask

  task automatic test_drop_req();
    int pulses [2];
    idle_both();
    set_m1(1, 0, 32'h100, 32'h0, 3'b010);
    for (int c = 1; c <= 5; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          failures++; $display("FAIL m1_read inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
      checks++;
      if (m1_ready_o[1] !== (c == 2) || (c == 2 && m1_rdata_o[1] !== rd_fn(32'h100))) begin
        failures++; $display("FAIL m1_read_w0 cyc=%0d got rdy=%b rdata=%h", c, m1_ready_o[1], m1_rdata_o[1]);
      end
      if (c == 3) m1_req = 0;
    end
    idle_both();
    set_m1(1, 0, 32'h104, 32'h0, 3'b010);
    pulses[0] = 0; pulses[1] = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      m1_req = 0;
      for (int k = 0; k < 2; k++) begin
        if (m1_ready_o[k] === 1'b1) pulses[k]++;
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          failures++; $display("FAIL m1_drop inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pulses[k] != 1 || busy_o[k] !== 1'b0) begin
        failures++; $display("FAIL m1_drop_pulses inst=%0d got pulses=%0d busy=%b want 1 and 0", k, pulses[k], busy_o[k]);
      end
    end
  endtask

  task automatic test_isolation();
    idle_both();
    set_m0(1, 0, 32'h30, 32'h0, 3'b010);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) set_m1(1, 1, 32'h200, 32'h7777_0001, 3'b001);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          failures++; $display("FAIL isolation inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
      checks++;
      if ((c == 3 && (m0_ready_o[0] !== 1'b1 || m1_ready_o[0] !== 1'b0)) || (c == 4 && busy_o[0] !== 1'b0)
          || (c == 5 && (busy_o[0] !== 1'b1 || grant_id_o[0] !== 1'b1)) || (c == 7 && m1_ready_o[0] !== 1'b1)) begin
        failures++; $display("FAIL isolation_seq cyc=%0d got r0=%b r1=%b busy=%b gid=%b", c,
                             m0_ready_o[0], m1_ready_o[0], busy_o[0], grant_id_o[0]);
      end
      if (c == 3) m0_req = 0;
      if (c == 7) m1_req = 0;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      set_m0($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom, 3'($urandom_range(0, 7)));
      set_m1($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 63) == 0) begin
        reset = 0; model_reset();
        tick();
        reset = 1;
      end else begin
        tick();
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          failures++; $display("FAIL random inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
    end
    idle_both();
  endtask

  initial begin
    reset = 1;
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    model_reset();
    #1 reset = 0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_tie();
    test_async_reset();
    test_drop_req();
    test_isolation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
Two-master, single-slave arbiter and wait-state sequencer for the shared data memory / MMIO port. Master 0 is the CPU MEM-stage data port (address, write data, write strobe, Dm_ctrl). Master 1 is a secondary requester such as a DMA or debug loader. The block grants one master at a time, drives the slave for a fixed wait-state count, and returns read data plus a one-cycle ready pulse. The CPU uses m0_ready to release its MEM-stage stall.

Parameters:
WAIT_CYCLES, 1, extra slave access cycles; ACCESS lasts WAIT_CYCLES+1 cycles; legal range 0..15.
CNT_W, 4, wait counter width; must satisfy 2^CNT_W > WAIT_CYCLES.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
m0_req  in  1  CPU access request; held high until m0_ready.
m0_we  in  1  CPU write (1) / read (0).
m0_addr  in  32  CPU byte address.
m0_wdata  in  32  CPU store data.
m0_dm_ctrl  in  3  CPU access size/sign code (Dm_ctrl encoding).
m0_ready  out  1  one-cycle completion pulse to CPU.
m0_rdata  out  32  read data to CPU; valid while m0_ready=1.
m1_req, m1_we, m1_addr, m1_wdata, m1_dm_ctrl, m1_ready, m1_rdata: same as m0_* for master 1.
s_addr  out  32  slave address.
s_wdata  out  32  slave write data.
s_dm_ctrl  out  3  slave size code.
s_we  out  1  slave write strobe.
s_rdata  in  32  slave read data; valid in the final ACCESS cycle.
busy  out  1  high whenever state != IDLE.
grant_id  out  1  master currently owning the bus; meaningful only while busy=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, last_grant=1.
  - All outputs 0: s_*, m*_ready, m*_rdata, busy, grant_id.
  - Reset during ACCESS aborts the transfer; no s_we pulse is issued after reset asserts.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that master.
  - Both requesting: grant the master != last_grant (round robin), so m0 wins the first tie after reset.
  - On grant:
    - latch we/addr/wdata/dm_ctrl of the winner into request registers;
    - set grant_id and last_grant;
    - set cnt=WAIT_CYCLES;
    - go to ACCESS.
- ACCESS:
  - s_addr, s_wdata and s_dm_ctrl are driven from the latched request registers for every ACCESS cycle.
  - cnt!=0: decrement cnt and stay.
  - cnt==0 (final cycle):
    - s_we = latched we (single-cycle write strobe);
    - if latched we=0, sample s_rdata into the rdata register;
    - go to RESP.
  - s_we=0 in all other cycles and states.
- RESP (exactly one cycle):
  - m[grant_id]_ready=1; m[grant_id]_rdata = latched data (0 for writes).
  - The other master's ready=0.
  - Next state is IDLE; s_* outputs return to 0.
- Latency: request sampled at edge E0 → ACCESS spans cycles E0+1..E0+1+WAIT_CYCLES → ready high in cycle E0+2+WAIT_CYCLES.
  - Minimum request-to-request spacing is WAIT_CYCLES+3 cycles, because IDLE occupies one cycle.
- mX_rdata holds its value after ready deasserts, until overwritten by the next read to that master.
- Request inputs are ignored outside IDLE. A master that drops req mid-transfer still gets its ready pulse, and the slave access still completes.
- A master still requesting after its RESP cycle re-arbitrates normally. If the other master is also requesting, it wins (round robin), which guarantees no starvation.
- Address alignment is not checked; alignment exceptions belong to the CPU EX stage.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - master ID constants (MST_CPU=1'b0, MST_AUX=1'b1);
  - Dm_ctrl width constant (3), reusing the existing ctrl encoding definitions.
- One sub-module, rr_arb2: combinational 2-way round-robin pick from (req0, req1, last_grant), producing grant_valid and grant_id. The FSM, counter and request registers stay in dmem_bus_arbiter.

Test Plan:
1. WAIT_CYCLES=1, CPU read: m0_req=1, m0_we=0, m0_addr=0x0000_0010 sampled at E0.
   → s_addr=0x10 in cycles E0+1..E0+2; s_rdata=0xDEAD_BEEF in E0+2; m0_ready=1 and m0_rdata=0xDEAD_BEEF in E0+3; busy=0 in E0+4.
2. CPU write: m0_we=1, m0_addr=0x20, m0_wdata=0x1234_5678, m0_dm_ctrl=3'b000.
   → s_we=1 for exactly cycle E0+2 with s_wdata=0x1234_5678; m0_ready pulses in E0+3; m0_rdata=0.
3. Tie after reset: m0_req and m1_req both held high.
   → grant_id=0 first, then grant_id=1, then 0; ready pulses alternate m0, m1, m0, each 4 cycles apart.
4. Asynchronous reset mid-transfer: assert reset=0 during the first ACCESS cycle of a write.
   → all outputs 0 immediately; s_we never pulses; after release, the first tie grants m0.
5. WAIT_CYCLES=0, m1 read of addr 0x100: ACCESS lasts 1 cycle, m1_ready in E0+2. Then m1 drops req during ACCESS on a second transfer → m1_ready still pulses once; no further grant.
6. Non-owner isolation: m1_req rises while m0 is in ACCESS.
   → m1 request is ignored until IDLE, then granted; m1_ready never asserts in m0's RESP cycle.
